// File: rtl/mips_fetch_unit_pkg.sv
// Shared encodings and constants for the MIPS fetch unit and its next-PC helper.
package mips_fetch_unit_pkg;

    typedef enum logic [1:0] {
        CT_SEQ    = 2'b00,
        CT_BRANCH = 2'b01,
        CT_JUMP   = 2'b10,
        CT_JR     = 2'b11
    } ctrl_t;

    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_EXCEPT   = 2'b01,
        HC_MISALIGN = 2'b10,
        HC_TIMEOUT  = 2'b11
    } halt_cause_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_READY = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [3:0]  WAIT_LIMIT = 4'd15;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and memory.
interface mips_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/mips_fetch_unit_next_pc.sv
// Combinational next-PC select: fallthrough, PC-relative branch, region jump, or register jump.
module mips_next_pc
    import mips_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  control_type,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);
    logic [31:0] pc_plus4;
    logic [31:0] branch_disp;

    assign pc_plus4    = pc + 32'd4;
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (ctrl_t'(control_type))
            CT_SEQ:    next_pc = pc_plus4;
            CT_BRANCH: next_pc = pc_plus4 + branch_disp;
            CT_JUMP:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
            CT_JR:     next_pc = jr_target;
            default:   next_pc = pc_plus4;
        endcase
    end
endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch unit: requests the word at pc, holds it for decode, then steps pc by the
// decoder's control selection. Halts terminally on exceptions, misaligned jr or memory timeout.
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         control_type,
    input  logic               except,
    input  logic [15:0]        branch_offset,
    input  logic [25:0]        jump_index,
    input  logic [31:0]        jr_target,
    input  logic               advance,
    mips_fetch_unit_if.master  imem,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic               halted,
    output logic [1:0]         halt_cause
);
    state_t      state;
    logic [3:0]  wait_cnt;
    logic        req_q;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    mips_next_pc u_next_pc (
        .pc            (pc),
        .control_type  (control_type),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .next_pc       (next_pc)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign jr_misaligned  = (ctrl_t'(control_type) == CT_JR) && (jr_target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            inst       <= '0;
            wait_cnt   <= '0;
            halt_cause <= HC_NONE;
            req_q      <= 1'b0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // Only the first cycle out of reset has req low here; raise it, ignore ack.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem.imem_ack) begin
                        inst       <= imem.imem_rdata;
                        wait_cnt   <= '0;
                        req_q      <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= ST_READY;
                    end else if (wait_cnt == WAIT_LIMIT - 4'd1) begin
                        wait_cnt   <= WAIT_LIMIT;
                        req_q      <= 1'b0;
                        halted     <= 1'b1;
                        halt_cause <= HC_TIMEOUT;
                        state      <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_READY: begin
                    if (advance) begin
                        inst_valid <= 1'b0;
                        if (except) begin
                            halted     <= 1'b1;
                            halt_cause <= HC_EXCEPT;
                            state      <= ST_HALT;
                        end else if (jr_misaligned) begin
                            halted     <= 1'b1;
                            halt_cause <= HC_MISALIGN;
                            state      <= ST_HALT;
                        end else begin
                            pc    <= next_pc;
                            req_q <= 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    req_q      <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    req_q      <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                    state      <= ST_HALT;
                end
            endcase
        end
    end
endmodule
